// File: rtl/xbus_rr_sched.sv
// Round-robin owner of the shared X data bus: grants one row buffer at a time
// for a kernel_size-beat burst and stamps each beat with its X tag (1..K).
module xbus_rr_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 10,
  parameter int NUM_ROW    = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic [7:0]                      kernel_size,
  input  logic [NUM_ROW-1:0]              req,
  input  logic [NUM_ROW*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_ROW-1:0]              gnt,
  input  logic                            bus_ready,
  output logic                            bus_valid,
  output logic [DATA_WIDTH-1:0]           bus_data,
  output logic [$clog2(NUM_COL):0]        bus_tag,
  output logic [$clog2(NUM_ROW)-1:0]      owner,
  output logic                            busy,
  output logic                            cfg_err
);

  localparam int TW = $clog2(NUM_COL) + 1;
  localparam int PW = $clog2(NUM_ROW);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   owner_reg, owner_next;
  logic [TW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [TW-1:0]   k_lat_reg, k_lat_next;
  logic            cfg_err_reg, cfg_err_next;

  logic [DATA_WIDTH-1:0] row_data [NUM_ROW];
  logic                  in_burst;
  logic                  accept;
  logic                  k_ok;
  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [PW-1:0]         owner_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROW; gi++) begin : g_row
      assign row_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign gnt[gi]      = accept && (owner_reg == PW'(gi));
    end
  endgenerate

  // Flush masks the bus in the same cycle so a coinciding beat is never popped.
  assign in_burst  = (state_reg == ST_BURST);
  assign bus_valid = in_burst && req[owner_reg] && !flush;
  assign accept    = bus_valid && bus_ready;
  assign bus_data  = in_burst ? row_data[owner_reg] : '0;
  assign bus_tag   = in_burst ? beat_cnt_reg : '0;
  assign owner     = owner_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign cfg_err   = cfg_err_reg;

  assign k_ok      = (kernel_size != 8'd0) && (kernel_size <= 8'(NUM_COL));
  assign owner_inc = (owner_reg == PW'(NUM_ROW - 1)) ? '0 : owner_reg + 1'b1;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_ROW; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= NUM_ROW) cand = cand - NUM_ROW;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    beat_cnt_next = beat_cnt_reg;
    k_lat_next    = k_lat_reg;
    cfg_err_next  = cfg_err_reg;
    if (flush) begin
      state_next    = ST_FLUSH;
      beat_cnt_next = '0;
      ptr_next      = '0;
      owner_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            if (k_ok) begin
              owner_next    = win_idx;
              k_lat_next    = TW'(kernel_size);
              beat_cnt_next = TW'(1);
              state_next    = ST_BURST;
            end else begin
              cfg_err_next = 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (accept) begin
            if (beat_cnt_reg == k_lat_reg) begin
              ptr_next      = owner_inc;
              beat_cnt_next = '0;
              state_next    = ST_IDLE;
            end else begin
              beat_cnt_next = beat_cnt_reg + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          beat_cnt_next = '0;
          ptr_next      = '0;
          owner_next    = '0;
          state_next    = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      beat_cnt_reg <= '0;
      k_lat_reg    <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      beat_cnt_reg <= beat_cnt_next;
      k_lat_reg    <= k_lat_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

endmodule

// File: tb/tb_xbus_rr_sched.sv
// Directed bench for xbus_rr_sched: burst-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_xbus_rr_sched;

  localparam int DW = 16;
  localparam int NC = 10;
  localparam int NR = 2;
  localparam int TW = $clog2(NC) + 1;
  localparam int PW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic [7:0]        kernel_size;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              bus_ready;
  logic              bus_valid;
  logic [DW-1:0]     bus_data;
  logic [TW-1:0]     bus_tag;
  logic [PW-1:0]     owner;
  logic              busy;
  logic              cfg_err;

  int total = 0;
  int bad   = 0;

  xbus_rr_sched #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .kernel_size(kernel_size),
    .req(req), .req_data(req_data), .gnt(gnt), .bus_ready(bus_ready),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_tag(bus_tag),
    .owner(owner), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    req   = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  // Per-cycle changing payload so a wrong data mux shows up.
  initial begin
    logic [15:0] dcnt;
    dcnt = 16'd0;
    req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      req_data = {16'hB000 | dcnt, 16'hA000 | dcnt};
      dcnt = dcnt + 16'd1;
    end
  end

  // Reference model: burst-level bookkeeping (beats delivered so far, owner, fairness pointer).
  bit          m_burst = 0, m_flushing = 0, m_cfg = 0, found;
  int          m_owner = 0, m_ptr = 0, m_k = 0, m_done = 0, w, c;
  bit          exp_valid;
  logic [NR-1:0] exp_gnt;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = m_burst && req[m_owner] && !flush;
      exp_gnt   = (exp_valid && bus_ready) ? NR'(1 << m_owner) : '0;
      chk("mdl_gnt", 32'(gnt), 32'(exp_gnt));
      chk("mdl_valid", 32'(bus_valid), 32'(exp_valid));
      chk("mdl_busy", 32'(busy), 32'(m_burst || m_flushing));
      chk("mdl_owner", 32'(owner), 32'(m_owner));
      chk("mdl_cfg_err", 32'(cfg_err), 32'(m_cfg));
      if (exp_valid) begin
        chk("mdl_tag", 32'(bus_tag), 32'(m_done + 1));
        chk("mdl_data", 32'(bus_data), 32'(req_data[m_owner*DW +: DW]));
      end
      if (exp_valid && bus_ready)
        $display("beat t=%0t owner=%0d tag=%0d data=%h", $time, owner, bus_tag, bus_data);
      if (!rstn) begin
        m_burst = 0; m_flushing = 0; m_cfg = 0;
        m_owner = 0; m_ptr = 0; m_k = 0; m_done = 0;
      end else if (flush) begin
        m_burst = 0; m_flushing = 1; m_owner = 0; m_ptr = 0; m_done = 0;
      end else if (m_flushing) begin
        m_flushing = 0;
      end else if (m_burst) begin
        if (exp_valid && bus_ready) begin
          m_done++;
          if (m_done == m_k) begin
            m_burst = 0;
            m_ptr   = (m_owner + 1) % NR;
            m_done  = 0;
          end
        end
      end else if (req != '0) begin
        found = 0;
        w = 0;
        for (int i = 0; i < NR; i++) begin
          c = (m_ptr + i) % NR;
          if (!found && req[c]) begin
            found = 1;
            w = c;
          end
        end
        if (kernel_size >= 8'd1 && kernel_size <= 8'(NC)) begin
          m_burst = 1; m_owner = w; m_k = int'(kernel_size); m_done = 0;
        end else begin
          m_cfg = 1;
        end
      end
    end
  end

  int exp_gnt2 [12] = '{1, 1, 1, 0, 2, 2, 2, 0, 1, 1, 1, 0};
  int exp_tag2 [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int pulses;
  int tags3 [$];

  initial begin
    rstn = 1'b0; flush = 1'b0; kernel_size = 8'd3; req = 2'b11; bus_ready = 1'b1;

    // Reset held three edges with both requesters asking.
    repeat (3) step();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_owner", 32'(owner), 0);
    step();
    rstn = 1'b1;

    // K=3, both requesting: bursts alternate with one arbitration cycle between.
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_gnt2[i]));
      if (exp_gnt2[i] != 0) chk($sformatf("rr_tag%0d", i), 32'(bus_tag), 32'(exp_tag2[i]));
    end
    step();
    quiesce();

    // K=7, requester 1 alone, bus_ready toggling.
    kernel_size = 8'd7;
    req = 2'b10;
    pulses = 0;
    for (int cyc = 0; cyc < 40 && pulses < 7; cyc++) begin
      step();
      bus_ready = ~bus_ready;
      @(negedge clk);
      if (gnt[1]) begin
        pulses++;
        tags3.push_back(int'(bus_tag));
      end
    end
    chk("stall_pulses", 32'(pulses), 7);
    for (int i = 0; i < tags3.size(); i++)
      chk($sformatf("stall_tag%0d", i), 32'(tags3[i]), 32'(i + 1));
    step();
    req = '0;
    bus_ready = 1'b1;
    step();
    quiesce();

    // Flush on tag 2 of requester 1's burst; afterwards pointer restarts at 0.
    kernel_size = 8'd3;
    req = 2'b11;
    repeat (6) step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_gnt", 32'(gnt), 0);
    chk("flush_valid", 32'(bus_valid), 0);
    chk("flush_owner", 32'(owner), 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("post_flush_idle", 32'(busy), 0);
    step();
    @(negedge clk);
    chk("post_flush_owner", 32'(owner), 0);
    chk("post_flush_tag", 32'(bus_tag), 1);
    chk("post_flush_gnt", 32'(gnt), 1);
    step();
    quiesce();

    // Illegal kernel sizes: no grant, sticky cfg_err.
    chk("cfg_clear", 32'(cfg_err), 0);
    kernel_size = 8'd0;
    req = 2'b01;
    repeat (3) begin
      step();
      @(negedge clk);
      chk("k0_gnt", 32'(gnt), 0);
    end
    chk("k0_cfg_err", 32'(cfg_err), 1);
    step();
    kernel_size = 8'd11;
    repeat (3) begin
      step();
      @(negedge clk);
      chk("k11_gnt", 32'(gnt), 0);
      chk("k11_busy", 32'(busy), 0);
    end
    step();
    kernel_size = 8'd3;
    step();
    @(negedge clk);
    chk("k3_gnt", 32'(gnt), 1);
    chk("k3_tag", 32'(bus_tag), 1);
    chk("k3_cfg_err", 32'(cfg_err), 1);
    step();
    step();
    quiesce();
    chk("cfg_after_flush", 32'(cfg_err), 1);

    // kernel_size changes mid-burst: latched value governs.
    kernel_size = 8'd3;
    req = 2'b01;
    step();
    step();
    kernel_size = 8'd7;
    @(negedge clk);
    chk("kchg_tag2", 32'(bus_tag), 2);
    step();
    @(negedge clk);
    chk("kchg_tag3", 32'(bus_tag), 3);
    chk("kchg_gnt3", 32'(gnt), 1);
    step();
    @(negedge clk);
    chk("kchg_idle", 32'(busy), 0);
    for (int i = 0; i < 7; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("k7_tag%0d", i + 1), 32'(bus_tag), 32'(i + 1));
      chk($sformatf("k7_gnt%0d", i + 1), 32'(gnt), 1);
    end
    step();
    @(negedge clk);
    chk("k7_end_idle", 32'(busy), 0);
    step();
    quiesce();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbus_rr_sched.md
Name: xbus_rr_sched

Overview:
- Round-robin scheduler that shares the single X data bus between NUM_ROW row-buffer requesters.
- Grants one requester at a time for a burst of exactly kernel_size beats. Stamps each beat with the X tag (1..kernel_size) that tagAlloc-locked PE columns match against.
- Sits between the row buffers and X_BusCtrl/glb_PE array. Obeys the array-wide flush.

Parameters:
- DATA_WIDTH, 16, bus data width
- NUM_COL, 10, PE columns; maximum legal kernel_size
- NUM_ROW, 2, number of requesters (>=2)

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset, sampled on rising clk
- flush  in  1  level; abort and hold scheduler while high
- kernel_size  in  8  burst length / tag range; sampled at burst start
- req  in  NUM_ROW  per-requester data-valid, level
- req_data  in  NUM_ROW*DATA_WIDTH  packed data, requester r at [r*DATA_WIDTH +: DATA_WIDTH]
- gnt  out  NUM_ROW  one-hot beat-accept; requester pops its data this cycle
- bus_ready  in  1  PE array accepts beat
- bus_valid  out  1  beat on bus
- bus_data  out  DATA_WIDTH  beat data
- bus_tag  out  $clog2(NUM_COL)+1  X tag of beat; 0 = none
- owner  out  $clog2(NUM_ROW)  current burst owner (debug)
- busy  out  1  state != IDLE
- cfg_err  out  1  sticky: illegal kernel_size seen at arbitration

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rstn.
- Reset (rstn=0 at a clk edge) has priority over everything:
  - state=IDLE, rr pointer=0, beat counter=0, latched K=0, owner=0, cfg_err=0.
  - All outputs are 0 at the first edge with rstn=0.
- Registered state: state, ptr, owner, beat_cnt, K_lat, cfg_err.
- bus_valid, bus_data, bus_tag and gnt are combinational from registered state plus req/bus_ready/flush.
- FSM states:
  - IDLE:
    - If flush=1, go to FLUSH.
    - Else, if any req, search round-robin starting at ptr; winner w.
    - If 1<=kernel_size<=NUM_COL: owner<=w, K_lat<=kernel_size, beat_cnt<=1, go to BURST.
    - Otherwise: cfg_err<=1, stay in IDLE, no grant.
    - Arbitration costs 1 cycle: req seen at edge n gives first possible beat in cycle n+1.
  - BURST:
    - bus_valid = req[owner] & ~flush.
    - bus_data = req_data[owner]; bus_tag = beat_cnt.
    - gnt[owner] = bus_valid & bus_ready; other gnt bits are 0.
    - Stall (owner req=0 or bus_ready=0): beat_cnt, tag and owner hold. There is no timeout.
    - On an accepted beat with beat_cnt<K_lat: beat_cnt++.
    - On an accepted beat with beat_cnt==K_lat: ptr<=owner+1 (mod NUM_ROW), beat_cnt<=0, go to IDLE.
    - There is no back-to-back burst without the IDLE arbitration cycle.
  - FLUSH:
    - All bus outputs and gnt are 0.
    - beat_cnt<=0, ptr<=0, owner<=0.
    - Exit to IDLE on the first edge with flush=0.
- flush in any state:
  - Combinationally masks bus_valid/gnt in the same cycle, so a beat coinciding with the flush rising edge is not transferred.
  - Next state is FLUSH; any partial burst is discarded.
- kernel_size changes mid-burst are ignored (K_lat is used). The new value applies at the next arbitration.
- Requester lowers req mid-burst: the burst stalls and keeps ownership. Other requesters wait.
- bus_tag width is $clog2(NUM_COL)+1 so tag NUM_COL is representable.
- cfg_err clears only on reset. flush does not clear it.
- Only one gnt bit is ever high. gnt is never high unless bus_valid & bus_ready.

Test Plan:
1. Reset sequence: rstn low 3 cycles with req=2'b11 -> gnt=0, bus_valid=0, busy=0, cfg_err=0. First grant to requester 0 one cycle after rstn rises.
2. K=3, req=2'b11, bus_ready=1 -> tags 1,2,3 with owner 0 and gnt=01 for 3 cycles; 1 IDLE cycle; then tags 1,2,3 with owner 1 and gnt=10; then owner 0 again (fairness alternates).
3. K=7, single requester, bus_ready toggled 1,0,1,... -> exactly 7 gnt pulses. bus_tag holds during stalls. Sequence 1..7 is gap-tolerant and monotonic.
4. flush=1 asserted on the beat with tag 2 of a K=3 burst -> that beat is not granted. busy=1 in FLUSH. After flush=0: IDLE, ptr=0, new burst restarts at tag 1 from requester 0.
5. kernel_size=0, then 11 (NUM_COL=10), with req high -> no gnt, cfg_err=1 and stays 1. Change to K=3 -> normal burst proceeds while cfg_err remains 1.
6. kernel_size changed 3->7 on beat 2 -> burst ends after tag 3. The next burst uses tags 1..7.
